// File: rtl/rng_request_arbiter.sv
// ---------------------------------------------------------------------------
// rng_request_arbiter : round-robin sharing of one random_num_gen with watchdog
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rng_request_arbiter #(
  parameter int              NREQ    = 4,
  parameter int              NBITS   = 256,
  parameter int              TMO_W   = 16,
  parameter logic [TMO_W-1:0] TMO_CYC = 16'd40000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [11:0]      cfg_maxbits,
  input  logic             cfg_bypass,
  output logic [NREQ-1:0]  gnt,
  output logic             rsp_valid,
  output logic [2:0]       rsp_id,
  output logic             rsp_err,
  output logic [NBITS-1:0] rsp_data,
  output logic             busy,
  output logic             rng_enable_p,
  output logic [11:0]      rng_maxbits,
  output logic             rng_bypass,
  input  logic             rng_done_p,
  input  logic [NBITS-1:0] rng_y
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_COOL  = 3'd4
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_CYC - TMO_W'(1);
  localparam logic [2:0]       LAST_IDX = 3'(NREQ - 1);

  state_t           state;
  state_t           state_nx;
  logic [2:0]       rr_ptr;
  logic [2:0]       gidx;
  logic [2:0]       pick_idx;
  logic             pick_ok;
  logic [7:0]       req_pad;
  logic [TMO_W-1:0] watchdog;
  logic             wait_done;
  logic             wait_tmo;

  function automatic logic [2:0] wrap_idx(input logic [2:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return 3'(s);
  endfunction

  assign req_pad = 8'(req);

  // Walk downward so the lowest offset from rr_ptr is the last (winning) hit
  always_comb begin
    pick_ok  = 1'b0;
    pick_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_pad[wrap_idx(rr_ptr, k)]) begin
        pick_ok  = 1'b1;
        pick_idx = wrap_idx(rr_ptr, k);
      end
    end
  end

  always_comb begin
    state_nx  = state;
    wait_done = 1'b0;
    wait_tmo  = 1'b0;
    unique case (state)
      S_IDLE:  if (pick_ok) state_nx = S_START;
      S_START: state_nx = (rng_maxbits == '0) ? S_RESP : S_WAIT;
      S_WAIT: begin
        wait_done = rng_done_p;
        wait_tmo  = !rng_done_p && (watchdog == TMO_LAST);
        if (wait_done || wait_tmo) state_nx = S_RESP;
      end
      S_RESP:  state_nx = S_COOL;
      S_COOL:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      gidx         <= '0;
      gnt          <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_err      <= 1'b0;
      rsp_data     <= '0;
      busy         <= 1'b0;
      rng_enable_p <= 1'b0;
      rng_maxbits  <= '0;
      rng_bypass   <= 1'b0;
      watchdog     <= '0;
    end else begin
      busy         <= (state_nx != S_IDLE);
      rng_enable_p <= 1'b0;
      rsp_valid    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_ok) begin
            gidx         <= pick_idx;
            gnt          <= NREQ'(8'd1 << pick_idx);
            rng_maxbits  <= cfg_maxbits;
            rng_bypass   <= cfg_bypass;
            // A zero bit count never starts the generator
            rng_enable_p <= (cfg_maxbits != '0);
          end
        end
        S_START: begin
          watchdog <= '0;
          if (rng_maxbits == '0) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
            rsp_id    <= gidx;
          end
        end
        S_WAIT: begin
          watchdog <= watchdog + TMO_W'(1);
          if (wait_done) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= rng_y;
            rsp_id    <= gidx;
          end else if (wait_tmo) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= '0;
            rsp_id    <= gidx;
          end
        end
        S_RESP: begin
          gnt    <= '0;
          rr_ptr <= (gidx == LAST_IDX) ? 3'd0 : gidx + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rng_request_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rng_request_arbiter : scoreboard bench for rng_request_arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rng_request_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req;
  logic [11:0]  cfg_maxbits;
  logic         cfg_bypass;
  logic [3:0]   gnt;
  logic         rsp_valid;
  logic [2:0]   rsp_id;
  logic         rsp_err;
  logic [255:0] rsp_data;
  logic         busy;
  logic         rng_enable_p;
  logic [11:0]  rng_maxbits;
  logic         rng_bypass;
  logic         rng_done_p;
  logic [255:0] rng_y;

  typedef struct {
    logic [2:0]   id;
    logic         err;
    logic [255:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   en_cnt  = 0;
  int   mptr    = 0;

  rng_request_arbiter #(
    .NREQ    (4),
    .NBITS   (256),
    .TMO_W   (16),
    .TMO_CYC (16'd100)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .cfg_maxbits  (cfg_maxbits),
    .cfg_bypass   (cfg_bypass),
    .gnt          (gnt),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_err      (rsp_err),
    .rsp_data     (rsp_data),
    .busy         (busy),
    .rng_enable_p (rng_enable_p),
    .rng_maxbits  (rng_maxbits),
    .rng_bypass   (rng_bypass),
    .rng_done_p   (rng_done_p),
    .rng_y        (rng_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[2'((p + k) % 4)]) return (p + k) % 4;
    return 0;
  endfunction

  // Response monitor: every rsp_valid must match the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rng_enable_p) en_cnt++;
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 256'(1), 256'(0));
        end else begin
          e = sb.pop_front();
          check("rsp_id",   256'(rsp_id),  256'(e.id));
          check("rsp_err",  256'(rsp_err), 256'(e.err));
          check("rsp_data", rsp_data,      e.data);
        end
      end
    end
  end

  task automatic wait_en;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (rng_enable_p) return;
    end
    check("en_timeout", 256'(0), 256'(1));
  endtask

  task automatic run_req(input int dly, input logic [255:0] y, input bit rearm);
    int id;
    id = rr_pick(req, mptr);
    wait_en;
    check("gnt", 256'(gnt), 256'(1) << id);
    sb.push_back('{id: 3'(id), err: 1'b0, data: y});
    repeat (dly) tick;
    rng_done_p = 1'b1;
    rng_y      = y;
    tick;
    rng_done_p = 1'b0;
    rng_y      = ~y;
    check("rsp_valid", 256'(rsp_valid), 256'(1));
    mptr = (id + 1) % 4;
    if (rearm) req[2'(id)] = 1'b0;
    else       req = 4'b0000;
    tick;
    check("cool_busy", 256'(busy), 256'(1));
    check("data_hold", rsp_data, y);
    if (rearm) req[2'(id)] = 1'b1;
    tick;
    check("idle_busy", 256'(busy), 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int en_base;
    int lat;
    rst_n       = 1'b0;
    req         = 4'b0000;
    cfg_maxbits = 12'd0;
    cfg_bypass  = 1'b0;
    rng_done_p  = 1'b0;
    rng_y       = '0;
    repeat (3) tick;
    check("rst_gnt",  256'(gnt),          256'(0));
    check("rst_busy", 256'(busy),         256'(0));
    check("rst_en",   256'(rng_enable_p), 256'(0));
    check("rst_rspv", 256'(rsp_valid),    256'(0));
    check("rst_data", rsp_data,           256'(0));
    rst_n = 1'b1;
    tick;

    // Single request with a 20-cycle generator
    cfg_maxbits = 12'd256;
    cfg_bypass  = 1'b1;
    en_base     = en_cnt;
    req         = 4'b0010;
    tick;
    check("s_gnt",     256'(gnt),          256'(4'b0010));
    check("s_en",      256'(rng_enable_p), 256'(1));
    check("s_maxbits", 256'(rng_maxbits),  256'(256));
    check("s_bypass",  256'(rng_bypass),   256'(1));
    sb.push_back('{id: 3'd1, err: 1'b0, data: {32{8'hA5}}});
    cfg_maxbits = 12'd7;
    cfg_bypass  = 1'b0;
    repeat (20) tick;
    rng_done_p = 1'b1;
    rng_y      = {32{8'hA5}};
    tick;
    rng_done_p = 1'b0;
    rng_y      = '1;
    check("s_rspv",    256'(rsp_valid),   256'(1));
    check("s_hold_mb", 256'(rng_maxbits), 256'(256));
    req = 4'b0000;
    tick;
    check("s_busy_cool", 256'(busy), 256'(1));
    tick;
    check("s_busy_idle", 256'(busy), 256'(0));
    check("s_en_count",  256'(en_cnt - en_base), 256'(1));
    mptr = 2;

    // Illegal config: zero bit count
    cfg_maxbits = 12'd0;
    en_base     = en_cnt;
    req         = 4'b0001;
    tick;
    check("ill_gnt", 256'(gnt),          256'(4'b0001));
    check("ill_en",  256'(rng_enable_p), 256'(0));
    sb.push_back('{id: 3'd0, err: 1'b1, data: 256'(0)});
    tick;
    check("ill_rspv", 256'(rsp_valid), 256'(1));
    req = 4'b0000;
    tick;
    tick;
    check("ill_en_count", 256'(en_cnt - en_base), 256'(0));
    mptr = 1;

    // Watchdog timeout, then a normal request with wrap-around priority
    cfg_maxbits = 12'd256;
    req         = 4'b0100;
    rng_y       = {8{32'hDEAD_BEEF}};
    wait_en;
    check("tmo_gnt", 256'(gnt), 256'(4'b0100));
    sb.push_back('{id: 3'd2, err: 1'b1, data: 256'(0)});
    lat = 0;
    for (int k = 1; k <= 150; k++) begin
      tick;
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    check("tmo_latency", 256'(lat), 256'(101));
    req  = 4'b0000;
    mptr = 3;
    tick;
    tick;
    req = 4'b1001;
    run_req(5, {8{32'h0BAD_F00D}}, 1'b0);

    // Spurious done in IDLE and in COOL
    rng_done_p = 1'b1;
    tick;
    rng_done_p = 1'b0;
    check("sp_idle_rspv", 256'(rsp_valid), 256'(0));
    check("sp_idle_busy", 256'(busy),      256'(0));
    tick;
    check("sp_idle_rspv2", 256'(rsp_valid), 256'(0));
    req = 4'b0001;
    wait_en;
    sb.push_back('{id: 3'd0, err: 1'b0, data: {8{32'h1357_9BDF}}});
    repeat (3) tick;
    rng_done_p = 1'b1;
    rng_y      = {8{32'h1357_9BDF}};
    tick;
    rng_done_p = 1'b0;
    check("sp_rspv", 256'(rsp_valid), 256'(1));
    req  = 4'b0000;
    mptr = 1;
    tick;
    rng_done_p = 1'b1;
    rng_y      = {8{32'hFFFF_0000}};
    tick;
    rng_done_p = 1'b0;
    check("sp_cool_busy", 256'(busy),      256'(0));
    check("sp_cool_rspv", 256'(rsp_valid), 256'(0));
    tick;
    check("sp_cool_rspv2", 256'(rsp_valid), 256'(0));
    check("sp_cool_data",  rsp_data,        {8{32'h1357_9BDF}});

    // done_p in the same cycle the watchdog expires
    req = 4'b0010;
    wait_en;
    check("race_gnt", 256'(gnt), 256'(4'b0010));
    sb.push_back('{id: 3'd1, err: 1'b0, data: {8{32'h2468_ACE0}}});
    repeat (100) tick;
    rng_done_p = 1'b1;
    rng_y      = {8{32'h2468_ACE0}};
    tick;
    rng_done_p = 1'b0;
    check("race_rspv", 256'(rsp_valid), 256'(1));
    req  = 4'b0000;
    mptr = 2;
    tick;
    tick;

    // Reset during WAIT discards the in-flight result
    req = 4'b0100;
    wait_en;
    repeat (4) tick;
    rst_n = 1'b0;
    #1;
    check("mr_gnt",     256'(gnt),         256'(0));
    check("mr_busy",    256'(busy),        256'(0));
    check("mr_maxbits", 256'(rng_maxbits), 256'(0));
    check("mr_data",    rsp_data,          256'(0));
    check("mr_id",      256'(rsp_id),      256'(0));
    req = 4'b0000;
    repeat (2) tick;
    rst_n = 1'b1;
    mptr  = 0;
    rng_done_p = 1'b1;
    rng_y      = {8{32'h7777_7777}};
    tick;
    rng_done_p = 1'b0;
    check("mr_rspv", 256'(rsp_valid), 256'(0));
    check("mr_busy2", 256'(busy),     256'(0));
    tick;
    check("mr_rspv2", 256'(rsp_valid), 256'(0));

    // Round-robin fairness with all requesters active
    req = 4'b1111;
    for (int i = 0; i < 5; i++)
      run_req(1 + i, {8{32'hC0DE_0000 + 32'(i)}}, (i < 4));

    repeat (3) tick;
    check("sb_empty", 256'(sb.size()), 256'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
